// File: rtl/block_unroller.sv
// block_unroller: buffers groups of up to N parallel trace blocks and replays
// them one block per cycle on a valid/ready stream. Each block goes out with
// its last-instruction and next-instruction addresses.
// Optional build macro BLOCK_UNROLLER_CHECK_EN enables the sticky protocol
// checker behind error_o. Without it, error_o is tied to 0.

package mure_pkg;
  parameter int XLEN        = 64;
  parameter int IRETIRE_LEN = 8;
  parameter int ITYPE_LEN   = 3;
  parameter int CAUSE_LEN   = 8;
  parameter int PRIV_LEN    = 2;
endpackage

module block_unroller
  import mure_pkg::*;
#(
  parameter int N          = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N-1:0]             valid_i,
  input  logic [N*IRETIRE_LEN-1:0] iretire_i,
  input  logic [N-1:0]             ilastsize_i,
  input  logic [N*ITYPE_LEN-1:0]   itype_i,
  input  logic [N*XLEN-1:0]        iaddr_i,
  input  logic [CAUSE_LEN-1:0]     cause_i,
  input  logic [XLEN-1:0]          tval_i,
  input  logic [PRIV_LEN-1:0]      priv_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [IRETIRE_LEN-1:0]   iretire_o,
  output logic                     ilastsize_o,
  output logic [ITYPE_LEN-1:0]     itype_o,
  output logic [XLEN-1:0]          iaddr_o,
  output logic [CAUSE_LEN-1:0]     cause_o,
  output logic [XLEN-1:0]          tval_o,
  output logic [PRIV_LEN-1:0]      priv_o,
  output logic [XLEN-1:0]          last_iaddr_o,
  output logic [XLEN-1:0]          next_iaddr_o,
  output logic                     full_o,
  output logic                     overflow_o,
  output logic                     error_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int UW = PW + 1;
  localparam int CW = $clog2(N) + 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {IDLE, EMIT} state_t;

  state_t state, state_next;

  logic [N*IRETIRE_LEN-1:0] mem_iretire   [FIFO_DEPTH];
  logic [N-1:0]             mem_ilastsize [FIFO_DEPTH];
  logic [N*ITYPE_LEN-1:0]   mem_itype     [FIFO_DEPTH];
  logic [N*XLEN-1:0]        mem_iaddr     [FIFO_DEPTH];
  logic [CW-1:0]            mem_count     [FIFO_DEPTH];
  logic [CAUSE_LEN-1:0]     mem_cause     [FIFO_DEPTH];
  logic [XLEN-1:0]          mem_tval      [FIFO_DEPTH];
  logic [PRIV_LEN-1:0]      mem_priv      [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [UW-1:0] usage, usage_next;
  logic [KW-1:0] slot, slot_next;
  logic [CW-1:0] in_count, head_count;
  logic          push, drop, pop, last_slot;

  logic [IRETIRE_LEN-1:0] head_iretire;
  logic                   head_ilastsize;
  logic [ITYPE_LEN-1:0]   head_itype;
  logic [XLEN-1:0]        head_iaddr;
  logic [XLEN-1:0]        head_next, head_last, size_bytes;
  logic                   head_trap;

  // Number of valid slots in the incoming group
  always_comb begin
    in_count = '0;
    for (int i = 0; i < N; i++) begin
      in_count = in_count + CW'(valid_i[i]);
    end
  end

  // Occupancy is the registered value, so a same-cycle pop never makes room for a push
  assign push       = (|valid_i) && (usage < UW'(FIFO_DEPTH));
  assign drop       = (|valid_i) && (usage == UW'(FIFO_DEPTH));
  assign head_count = mem_count[rd_ptr];
  assign last_slot  = (CW'(slot) + CW'(1)) == head_count;
  assign usage_next = usage + UW'(push) - UW'(pop);

  // Group storage is written on push only; the payload itself needs no reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_iretire[wr_ptr]   <= iretire_i;
      mem_ilastsize[wr_ptr] <= ilastsize_i;
      mem_itype[wr_ptr]     <= itype_i;
      mem_iaddr[wr_ptr]     <= iaddr_i;
      mem_count[wr_ptr]     <= in_count;
      mem_cause[wr_ptr]     <= cause_i;
      mem_tval[wr_ptr]      <= tval_i;
      mem_priv[wr_ptr]      <= priv_i;
    end
  end

  // Next-state logic: IDLE leaves on the push that fills the empty FIFO, so slot 0 is visible one cycle after the push
  always_comb begin
    state_next = state;
    slot_next  = slot;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        slot_next = '0;
        if (push) state_next = EMIT;
      end
      EMIT: begin
        if (ready_i) begin
          if (last_slot) begin
            pop       = 1'b1;
            slot_next = '0;
            if ((usage == UW'(1)) && !push) state_next = IDLE;
          end else begin
            slot_next = slot + KW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        slot_next  = '0;
      end
    endcase
  end

  // State, pointers, occupancy and the registered full/overflow flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      slot       <= '0;
      usage      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      full_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state  <= state_next;
      slot   <= slot_next;
      usage  <= usage_next;
      full_o <= (usage_next == UW'(FIFO_DEPTH));
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (drop) overflow_o <= 1'b1;
    end
  end

  // Select slot k of the head group and derive its addresses, modulo 2^XLEN
  always_comb begin
    head_iretire   = mem_iretire[rd_ptr][slot*IRETIRE_LEN +: IRETIRE_LEN];
    head_ilastsize = mem_ilastsize[rd_ptr][slot];
    head_itype     = mem_itype[rd_ptr][slot*ITYPE_LEN +: ITYPE_LEN];
    head_iaddr     = mem_iaddr[rd_ptr][slot*XLEN +: XLEN];
    head_next      = head_iaddr + (XLEN'(head_iretire) << 1);
    size_bytes     = head_ilastsize ? XLEN'(4) : XLEN'(2);
    head_last      = (head_iretire == '0) ? head_iaddr : (head_next - size_bytes);
    head_trap      = (head_itype == ITYPE_LEN'(1)) || (head_itype == ITYPE_LEN'(2));
  end

  // Output stage: every data output is zero whenever no block is being offered
  always_comb begin
    valid_o      = 1'b0;
    iretire_o    = '0;
    ilastsize_o  = 1'b0;
    itype_o      = '0;
    iaddr_o      = '0;
    cause_o      = '0;
    tval_o       = '0;
    priv_o       = '0;
    last_iaddr_o = '0;
    next_iaddr_o = '0;
    if (state == EMIT) begin
      valid_o      = 1'b1;
      iretire_o    = head_iretire;
      ilastsize_o  = head_ilastsize;
      itype_o      = head_itype;
      iaddr_o      = head_iaddr;
      priv_o       = mem_priv[rd_ptr];
      last_iaddr_o = head_last;
      next_iaddr_o = head_next;
      if (head_trap) begin
        cause_o = mem_cause[rd_ptr];
        tval_o  = mem_tval[rd_ptr];
      end
    end
  end

`ifdef BLOCK_UNROLLER_CHECK_EN
  logic [N:0] valid_ext;
  logic       group_fault;

  // Protocol faults of the incoming group; faulty groups are still stored unchanged
  always_comb begin
    valid_ext   = {1'b0, valid_i};
    group_fault = (valid_ext & (valid_ext + (N+1)'(1))) != '0;
    for (int i = 0; i < N; i++) begin
      if (valid_i[i]) begin
        if (iretire_i[i*IRETIRE_LEN +: IRETIRE_LEN] == '0) group_fault = 1'b1;
        if ((i > 0) && ((itype_i[i*ITYPE_LEN +: ITYPE_LEN] == ITYPE_LEN'(1)) ||
                        (itype_i[i*ITYPE_LEN +: ITYPE_LEN] == ITYPE_LEN'(2))))
          group_fault = 1'b1;
      end
    end
    if ((in_count > CW'(1)) && ((itype_i[ITYPE_LEN-1:0] == ITYPE_LEN'(1)) ||
                                (itype_i[ITYPE_LEN-1:0] == ITYPE_LEN'(2))))
      group_fault = 1'b1;
  end

  // Sticky error flag, raised only by groups that are actually accepted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      error_o <= 1'b0;
    end else if (push && group_fault) begin
      error_o <= 1'b1;
    end
  end
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_block_unroller.sv
// Testbench for block_unroller (N=2, FIFO_DEPTH=4). Uses directed scenarios
// plus randomized traffic, checked against a queue-of-groups reference model.
// Build with BLOCK_UNROLLER_CHECK_EN defined to also expect the error flag.

module tb_block_unroller;
  import mure_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]                  drv_valid = '0;
  logic [N-1:0][IRETIRE_LEN-1:0] drv_iretire = '0;
  logic [N-1:0]                  drv_ilastsize = '0;
  logic [N-1:0][ITYPE_LEN-1:0]   drv_itype = '0;
  logic [N-1:0][XLEN-1:0]        drv_iaddr = '0;
  logic [CAUSE_LEN-1:0]          drv_cause = '0;
  logic [XLEN-1:0]               drv_tval = '0;
  logic [PRIV_LEN-1:0]           drv_priv = '0;
  logic                          drv_ready = 1'b0;

  logic                   valid_o, ilastsize_o, full_o, overflow_o, error_o;
  logic [IRETIRE_LEN-1:0] iretire_o;
  logic [ITYPE_LEN-1:0]   itype_o;
  logic [XLEN-1:0]        iaddr_o, tval_o, last_iaddr_o, next_iaddr_o;
  logic [CAUSE_LEN-1:0]   cause_o;
  logic [PRIV_LEN-1:0]    priv_o;

  int compared   = 0;
  int mismatched = 0;

  block_unroller #(.N(N), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(drv_valid), .iretire_i(drv_iretire),
    .ilastsize_i(drv_ilastsize), .itype_i(drv_itype), .iaddr_i(drv_iaddr),
    .cause_i(drv_cause), .tval_i(drv_tval), .priv_i(drv_priv),
    .valid_o(valid_o), .ready_i(drv_ready), .iretire_o(iretire_o),
    .ilastsize_o(ilastsize_o), .itype_o(itype_o), .iaddr_o(iaddr_o),
    .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o),
    .last_iaddr_o(last_iaddr_o), .next_iaddr_o(next_iaddr_o),
    .full_o(full_o), .overflow_o(overflow_o), .error_o(error_o)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0][IRETIRE_LEN-1:0] iretire;
    logic [N-1:0]                  ilastsize;
    logic [N-1:0][ITYPE_LEN-1:0]   itype;
    logic [N-1:0][XLEN-1:0]        iaddr;
    int                            count;
    logic [CAUSE_LEN-1:0]          cause;
    logic [XLEN-1:0]               tval;
    logic [PRIV_LEN-1:0]           priv;
  } group_t;

  group_t model_q[$];
  int     model_k   = 0;
  bit     model_full = 1'b0;
  bit     model_ovf  = 1'b0;
  bit     model_err  = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic setSlot(input int s, input logic [IRETIRE_LEN-1:0] r, input logic ls,
                         input logic [ITYPE_LEN-1:0] t, input logic [XLEN-1:0] a);
    drv_iretire[s]   = r;
    drv_ilastsize[s] = ls;
    drv_itype[s]     = t;
    drv_iaddr[s]     = a;
  endtask

  function automatic bit isTrap(input logic [ITYPE_LEN-1:0] t);
    return (t == 1) || (t == 2);
  endfunction

  // Protocol faults straight from the rule list
  function automatic bit groupFault();
    int  c = $countones(drv_valid);
    bit  f = 1'b0;
    if (int'(drv_valid) != (1 << c) - 1) f = 1'b1;
    for (int s = 0; s < N; s++) begin
      if (drv_valid[s] && drv_iretire[s] == 0) f = 1'b1;
      if (drv_valid[s] && s > 0 && isTrap(drv_itype[s])) f = 1'b1;
    end
    if (c > 1 && isTrap(drv_itype[0])) f = 1'b1;
    return f;
  endfunction

  // Reference model step at a clock edge: consume a beat, then accept or drop the new group
  task automatic updateModel();
    int     used = model_q.size();
    group_t g;
    if (used > 0 && drv_ready) begin
      model_k++;
      if (model_k == model_q[0].count) begin
        void'(model_q.pop_front());
        model_k = 0;
      end
    end
    if (|drv_valid) begin
      if (used < DEPTH) begin
        g.iretire = drv_iretire; g.ilastsize = drv_ilastsize;
        g.itype = drv_itype; g.iaddr = drv_iaddr; g.count = $countones(drv_valid);
        g.cause = drv_cause; g.tval = drv_tval; g.priv = drv_priv;
        model_q.push_back(g);
        if (groupFault()) model_err = 1'b1;
      end else begin
        model_ovf = 1'b1;
      end
    end
    model_full = (model_q.size() == DEPTH);
  endtask

  // Compare every output with the beat the model says should be on the stream
  task automatic checkAll();
    logic [63:0] e_valid = 0, e_ret = 0, e_ls = 0, e_type = 0, e_addr = 0;
    logic [63:0] e_cause = 0, e_tval = 0, e_priv = 0, e_last = 0, e_next = 0, e_err;
    if (model_q.size() > 0) begin
      e_valid = 1;
      e_ret   = 64'(model_q[0].iretire[model_k]);
      e_ls    = 64'(model_q[0].ilastsize[model_k]);
      e_type  = 64'(model_q[0].itype[model_k]);
      e_addr  = model_q[0].iaddr[model_k];
      e_next  = e_addr + 2 * e_ret;
      e_last  = (e_ret == 0) ? e_addr : e_next - (e_ls[0] ? 64'd4 : 64'd2);
      e_priv  = 64'(model_q[0].priv);
      if (isTrap(model_q[0].itype[model_k])) begin
        e_cause = 64'(model_q[0].cause);
        e_tval  = model_q[0].tval;
      end
    end
`ifdef BLOCK_UNROLLER_CHECK_EN
    e_err = 64'(model_err);
`else
    e_err = 0;
`endif
    checkOutput("valid_o",      64'(valid_o),      e_valid);
    checkOutput("iretire_o",    64'(iretire_o),    e_ret);
    checkOutput("ilastsize_o",  64'(ilastsize_o),  e_ls);
    checkOutput("itype_o",      64'(itype_o),      e_type);
    checkOutput("iaddr_o",      iaddr_o,           e_addr);
    checkOutput("cause_o",      64'(cause_o),      e_cause);
    checkOutput("tval_o",       tval_o,            e_tval);
    checkOutput("priv_o",       64'(priv_o),       e_priv);
    checkOutput("last_iaddr_o", last_iaddr_o,      e_last);
    checkOutput("next_iaddr_o", next_iaddr_o,      e_next);
    checkOutput("full_o",       64'(full_o),       64'(model_full));
    checkOutput("overflow_o",   64'(overflow_o),   64'(model_ovf));
    checkOutput("error_o",      64'(error_o),      e_err);
  endtask

  // Drive at the falling edge, let one rising edge pass, compare at the next falling edge
  task automatic applyStimulus(input logic [N-1:0] v, input logic rdy);
    drv_valid = v;
    drv_ready = rdy;
    @(posedge clk);
    updateModel();
    @(negedge clk);
    drv_valid = '0;
    checkAll();
  endtask

  task automatic doReset();
    rst       = 1'b1;
    drv_valid = '0;
    @(posedge clk);
    model_q.delete();
    model_k = 0; model_full = 1'b0; model_ovf = 1'b0; model_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkAll();
  endtask

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] v;
    @(negedge clk);
    doReset();

    // Single block
    setSlot(0, 6, 1'b1, 3, 64'h8000_0000);
    applyStimulus(2'b01, 1'b1);
    checkOutput("single_valid", 64'(valid_o), 64'd1);
    checkOutput("single_next", next_iaddr_o, 64'h8000_000C);
    checkOutput("single_last", last_iaddr_o, 64'h8000_0008);
    checkOutput("single_cause", 64'(cause_o), 64'd0);
    applyStimulus(2'b00, 1'b1);
    checkOutput("single_gone", 64'(valid_o), 64'd0);

    // Two-slot group
    setSlot(0, 2, 1'b0, 0, 64'h100);
    setSlot(1, 4, 1'b1, 0, 64'h200);
    applyStimulus(2'b11, 1'b1);
    checkOutput("grp_slot0", iaddr_o, 64'h100);
    applyStimulus(2'b00, 1'b1);
    checkOutput("grp_slot1", iaddr_o, 64'h200);
    checkOutput("grp_slot1_next", next_iaddr_o, 64'h208);
    applyStimulus(2'b00, 1'b1);
    checkOutput("grp_popped", 64'(valid_o), 64'd0);

    // Backpressure on the second beat
    applyStimulus(2'b11, 1'b1);
    applyStimulus(2'b00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b00, 1'b0);
      checkOutput("bp_hold_valid", 64'(valid_o), 64'd1);
      checkOutput("bp_hold_addr", iaddr_o, 64'h200);
      checkOutput("bp_hold_last", last_iaddr_o, 64'h204);
    end
    applyStimulus(2'b00, 1'b1);
    checkOutput("bp_popped", 64'(valid_o), 64'd0);

    // Exception followed by an ordinary block, no bubble in between
    drv_cause = 8'h2; drv_tval = 64'hDEAD; drv_priv = 2'd3;
    setSlot(0, 3, 1'b1, 1, 64'h4000);
    applyStimulus(2'b01, 1'b1);
    checkOutput("exc_cause", 64'(cause_o), 64'h2);
    checkOutput("exc_tval", tval_o, 64'hDEAD);
    setSlot(0, 1, 1'b0, 0, 64'h5000);
    applyStimulus(2'b01, 1'b1);
    checkOutput("exc_next_cause", 64'(cause_o), 64'd0);
    checkOutput("exc_next_tval", tval_o, 64'd0);
    checkOutput("exc_next_priv", 64'(priv_o), 64'd3);
    applyStimulus(2'b00, 1'b1);

    // Overflow: five groups into a four-deep FIFO while stalled
    for (int g = 0; g < 5; g++) begin
      setSlot(0, IRETIRE_LEN'(g + 1), 1'b0, 0, 64'h1000 + 64'(g) * 64'h10);
      applyStimulus(2'b01, 1'b0);
      if (g == 3) checkOutput("ovf_full", 64'(full_o), 64'd1);
    end
    checkOutput("ovf_flag", 64'(overflow_o), 64'd1);
    for (int g = 0; g < 4; g++) begin
      checkOutput("ovf_order", iaddr_o, 64'h1000 + 64'(g) * 64'h10);
      applyStimulus(2'b00, 1'b1);
    end
    checkOutput("ovf_sticky", 64'(overflow_o), 64'd1);
    checkOutput("ovf_drained", 64'(valid_o), 64'd0);

    // Address wrap-around
    setSlot(0, 2, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFE);
    applyStimulus(2'b01, 1'b1);
    checkOutput("wrap_next", next_iaddr_o, 64'h2);
    checkOutput("wrap_last", last_iaddr_o, 64'h0);
    applyStimulus(2'b00, 1'b1);

    // Reset in the middle of a group
    setSlot(0, 2, 1'b0, 0, 64'h700);
    setSlot(1, 2, 1'b0, 0, 64'h800);
    applyStimulus(2'b11, 1'b0);
    doReset();
    checkOutput("rst_valid", 64'(valid_o), 64'd0);
    checkOutput("rst_ovf", 64'(overflow_o), 64'd0);
    applyStimulus(2'b00, 1'b1);
    checkOutput("rst_fifo_empty", 64'(valid_o), 64'd0);

    // Non-contiguous valid pattern
    setSlot(0, 0, 1'b0, 0, 64'h0);
    setSlot(1, 3, 1'b0, 0, 64'h300);
    applyStimulus(2'b10, 1'b1);
`ifdef BLOCK_UNROLLER_CHECK_EN
    checkOutput("err_noncontig", 64'(error_o), 64'd1);
`else
    checkOutput("err_disabled", 64'(error_o), 64'd0);
`endif
    applyStimulus(2'b00, 1'b1);
    doReset();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      int pick = $urandom_range(0, 9);
      v = (pick < 3) ? 2'b00 : (pick < 6) ? 2'b01 : (pick < 9) ? 2'b11 : 2'b10;
      for (int s = 0; s < N; s++) begin
        if (v[s])
          setSlot(s, ($urandom_range(0, 7) == 0) ? IRETIRE_LEN'(0) : IRETIRE_LEN'($urandom_range(1, 255)),
                  1'($urandom_range(0, 1)), ITYPE_LEN'($urandom_range(0, 4)),
                  ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(0, 255))
                                              : {$urandom, $urandom});
        else
          setSlot(s, 0, 1'b0, 0, 64'h0);
      end
      drv_cause = CAUSE_LEN'($urandom);
      drv_tval  = {$urandom, $urandom};
      drv_priv  = PRIV_LEN'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) doReset();
      else applyStimulus(v, ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
